// File: rtl/fetch_unit.sv
// fetch_unit: program counter, one-cycle ROM latency absorption and a two-entry
// output/skid buffer toward decode; redirects flush everything in flight.
`default_nettype none

module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     inflight_valid;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;
  logic                     skid_valid;
  logic [ADDRESS_WIDTH-1:0] skid_pc;
  logic [DATA_WIDTH-1:0]    skid_instr;

  logic out_free;
  logic skid_valid_next;
  logic issue;

  assign imem_addr = pc;

  always_comb begin
    out_free        = !out_valid || out_ready;
    skid_valid_next = skid_valid;
    if (out_free) begin
      // The skid only stays occupied if it drained into the output and a
      // response arrived behind it.
      skid_valid_next = skid_valid && inflight_valid;
    end else begin
      skid_valid_next = skid_valid || inflight_valid;
    end
    issue = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_instr      <= '0;
      skid_valid     <= 1'b0;
      skid_pc        <= '0;
      skid_instr     <= '0;
    end else if (redirect_valid) begin
      pc             <= redirect_pc & ~ADDRESS_WIDTH'(3);
      inflight_valid <= 1'b0;
      out_valid      <= 1'b0;
      skid_valid     <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_pc    <= skid_pc;
          out_instr <= skid_instr;
        end else if (inflight_valid) begin
          out_valid <= 1'b1;
          out_pc    <= inflight_pc;
          out_instr <= imem_rdata;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (inflight_valid && (!out_free || skid_valid)) begin
        skid_valid <= 1'b1;
        skid_pc    <= inflight_pc;
        skid_instr <= imem_rdata;
      end else if (out_free) begin
        skid_valid <= 1'b0;
      end

      if (issue) begin
        inflight_valid <= 1'b1;
        inflight_pc    <= pc;
        pc             <= pc + ADDRESS_WIDTH'(4);
      end else begin
        inflight_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the address input of the synchronous instruction ROM and delivers each returned instruction, with its PC, to decode. It owns the program counter and absorbs the ROM's one-cycle read latency. Decode backpressure is handled by a two-entry output register/skid buffer. Execute-stage redirects (taken branches, jumps) flush all in-flight and buffered fetches.

## Interface
- ADDRESS_WIDTH, 32, width of PC and ROM address
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- imem_addr  out  ADDRESS_WIDTH  byte address to ROM; equals pc register
- imem_rdata  in  DATA_WIDTH  ROM data for the address presented in the previous cycle
- redirect_valid  in  1  flush and load redirect_pc
- redirect_pc  in  ADDRESS_WIDTH  new fetch address; bits [1:0] ignored
- out_valid  out  1  out_pc/out_instr hold a valid instruction
- out_ready  in  1  decode accepts when out_valid && out_ready
- out_pc  out  ADDRESS_WIDTH  PC of the presented instruction
- out_instr  out  DATA_WIDTH  the presented instruction

## Operation
- State: pc; inflight_valid, inflight_pc (the read issued last cycle); output register (out_valid, out_pc, out_instr); skid register (skid_valid, skid_pc, skid_instr).
- Response: in a cycle where inflight_valid=1, imem_rdata belongs to inflight_pc.
- Drain: the output register is free when out_valid=0 or out_ready=1.
- Output register refill when free: from skid if skid_valid, otherwise from the response; otherwise out_valid<=0.
- Response routing:
  - If the skid fed the output and a response exists, the response goes to skid.
  - If the output is not free, the response goes to skid.
  - Otherwise the skid clears.
- Issue: a fetch issues in cycle t only if skid_valid will be 0 after edge t.
  - On issue: inflight_valid<=1, inflight_pc<=pc, pc<=pc+4.
  - Otherwise: inflight_valid<=0, pc held.
- The ROM reads every cycle regardless of issue. Non-issued reads are ignored.
- Skid never overflows; no instruction is dropped or duplicated under any out_ready pattern.
- PC arithmetic: pc+4 modulo 2^ADDRESS_WIDTH, so 0xFFFFFFFC wraps to 0x0. pc[1:0] is always 0; redirect_pc[1:0] is cleared on load.
- Redirect (priority over everything except rst):
  - pc<=redirect_pc&~3.
  - inflight_valid, skid_valid and out_valid all <=0, even if out_ready=0.
  - The response arriving in that cycle is discarded.
- Redirect held for N cycles reloads pc each cycle; fetch resumes after the last one.
- Reset: pc<=RESET_PC; out_valid, skid_valid, inflight_valid <=0; out_pc, out_instr, skid and inflight registers <=0. Reset asserted mid-stream discards everything at the next edge.

## Timing
- Reset values: imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- First cycle with rst=0 is cycle 0:
  - imem_addr=RESET_PC in cycle 0.
  - rdata returns in cycle 1.
  - out_valid=1 with out_pc=RESET_PC in cycle 2.
- Throughput: one instruction per cycle with out_ready held high.
- Redirect sampled in cycle t:
  - out_valid=0 in t+1.
  - imem_addr=redirect_pc in t+1.
  - out_valid=1 with out_pc=redirect_pc in t+3.
- Stall: out_pc/out_instr stable while out_valid && !out_ready. After out_ready returns, the next two instructions (output register then skid) appear on consecutive cycles with no bubble; fetch resumes in the cycle after the skid drains.
- All outputs are registered; no combinational path from out_ready or redirect_valid to any output.

## Test plan
- Reset release, out_ready=1, ROM word k = 0x1000_0000+k -> cycle 2: out_pc=0x0/out_instr=0x10000000; cycle 3: 0x4/0x10000001; cycle 4: 0x8/0x10000002.
- out_ready=0 for 3 cycles while out_pc=0x8 -> out_pc held at 0x8; after release, 0xC and 0x10 on consecutive cycles; no loss or duplicates.
- redirect_valid=1, redirect_pc=0x40 in cycle t while out_pc=0xC -> out_valid=0 at t+1 and t+2; out_pc=0x40 at t+3; 0x10 never appears.
- Redirect to 0x80 while out_ready=0 and skid full -> both buffered entries discarded; next valid out_pc=0x80.
- rst pulsed for one cycle mid-stream with out_ready=0 -> out_valid=0 the next cycle; stream restarts at RESET_PC two cycles after rst falls.
- Redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x0. Redirect to 0x43 -> out_pc=0x40.
